// File: rtl/quad_velocity_meter.sv
// quad_velocity_meter: x4 quadrature decoder with wrapping position count and gated signed velocity.
// Define QVM_AVG4_EN to report the mean of the last four windows (one extra cycle of latency).
module quad_velocity_meter #(
    parameter int GATE_CYCLES = 500000,
    parameter int CNT_W       = 20,
    parameter int POS_W       = 13,
    parameter int VEL_W       = 16
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             quadA,
    input  logic             quadB,
    input  logic             i_clear,
    output logic [POS_W-1:0] o_count,
    output logic [VEL_W-1:0] o_velocity,
    output logic             o_dir,
    output logic             o_valid,
    output logic             o_err
);
    localparam int ACC_W = VEL_W + 2;
    localparam logic signed [ACC_W-1:0] SAT = {2'b00, {VEL_W{1'b1}}};

    logic [1:0] a_sync_q, a_sync_d, b_sync_q, b_sync_d, prev_q, prev_d, cur, delta, step;
    logic [POS_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, sum, res;
    logic signed [ACC_W+1:0] rep;
    logic [VEL_W-1:0] vel_q, vel_d;
    logic dir_q, dir_d, valid_q, valid_d, err_q, err_d, illegal, terminal, close, take;
`ifdef QVM_AVG4_EN
    logic signed [ACC_W-1:0] hist_q [4];
    logic signed [ACC_W-1:0] hist_d [4];
    logic signed [ACC_W+1:0] total;
    logic pend_q, pend_d;
`endif

    always_comb begin
        a_sync_d = {a_sync_q[0], quadA};
        b_sync_d = {b_sync_q[0], quadB};
        cur      = {a_sync_q[1], b_sync_q[1]};
        prev_d   = cur;
        // Gray code 00,01,11,10 mapped onto 0..3: a legal step is a difference of +/-1 mod 4
        delta    = {cur[1], ^cur} - {prev_q[1], ^prev_q};
        illegal  = delta == 2'd2;
        step     = delta == 2'd1 ? 2'b01 : delta == 2'd3 ? 2'b11 : 2'b00;
        terminal = cnt_q == CNT_W'(GATE_CYCLES - 1);
        close    = terminal && !i_clear;
        count_d  = i_clear ? '0 : count_q + {{(POS_W-2){step[1]}}, step};
        sum      = acc_q + {{VEL_W{step[1]}}, step};
        res      = sum > SAT ? SAT : sum < -SAT ? -SAT : sum;
        cnt_d    = (i_clear || terminal) ? '0 : cnt_q + 1'b1;
        acc_d    = (i_clear || terminal) ? '0 : res;
        err_d    = !i_clear && (err_q || illegal);
`ifdef QVM_AVG4_EN
        hist_d[0] = i_clear ? '0 : close ? res : hist_q[0];
        for (int i = 1; i < 4; i++)
            hist_d[i] = i_clear ? '0 : close ? hist_q[i-1] : hist_q[i];
        total = '0;
        for (int i = 0; i < 4; i++)
            total = total + {{2{hist_q[i][ACC_W-1]}}, hist_q[i]};
        rep    = total >>> 2;
        pend_d = close;
        take   = pend_q;
`else
        rep  = {{2{res[ACC_W-1]}}, res};
        take = close;
`endif
        valid_d = take;
        vel_d   = take ? VEL_W'(rep < 0 ? -rep : rep) : vel_q;
        dir_d   = take ? rep < 0 : dir_q;
    end

    always_ff @(posedge clk or negedge n_reset)
        if (!n_reset) begin
            a_sync_q <= '0;
            b_sync_q <= '0;
            prev_q   <= '0;
            count_q  <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            vel_q    <= '0;
            dir_q    <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            a_sync_q <= a_sync_d;
            b_sync_q <= b_sync_d;
            prev_q   <= prev_d;
            count_q  <= count_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            vel_q    <= vel_d;
            dir_q    <= dir_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end

`ifdef QVM_AVG4_EN
    always_ff @(posedge clk or negedge n_reset)
        if (!n_reset) begin
            hist_q <= '{default: '0};
            pend_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
            pend_q <= pend_d;
        end
`endif

    assign o_count    = count_q;
    assign o_velocity = vel_q;
    assign o_dir      = dir_q;
    assign o_valid    = valid_q;
    assign o_err      = err_q;
endmodule

// File: tb/tb_quad_velocity_meter.sv
// tb_quad_velocity_meter: randomized and directed stimulus checked every cycle against a
// window-level reference model, plus literal expectations for the key scenarios.
`timescale 1ns/1ps
module tb_quad_velocity_meter;
    localparam int G     = 1000;
    localparam int CNT_W = 20;
    localparam int POS_W = 13;
    localparam int VEL_W = 16;
    localparam int SAT   = (1 << VEL_W) - 1;
`ifdef QVM_AVG4_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 0, n_reset = 0, quad_a = 0, quad_b = 0, i_clear = 0;
    logic [POS_W-1:0] o_count;
    logic [VEL_W-1:0] o_velocity;
    logic o_dir, o_valid, o_err;
    int total = 0, bad = 0;

    quad_velocity_meter #(.GATE_CYCLES(G), .CNT_W(CNT_W), .POS_W(POS_W), .VEL_W(VEL_W)) dut (
        .clk(clk), .n_reset(n_reset), .quadA(quad_a), .quadB(quad_b), .i_clear(i_clear),
        .o_count(o_count), .o_velocity(o_velocity), .o_dir(o_dir), .o_valid(o_valid), .o_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    int order[4] = '{0, 1, 3, 2};
    function automatic int ph(input int v);
        for (int i = 0; i < 4; i++) if (order[i] == v) return i;
        return 0;
    endfunction

    // Reference model: pin pairs as seen 1, 2 and 3 clock edges ago, then per-edge bookkeeping
    int pipe[3];
    int m_count, m_acc, m_phase, m_vel, m_d, m_s, m_t, m_pend;
    int wins[4];
    bit m_dir, m_valid, m_err;

    task automatic publish(input int v);
        m_vel   = v < 0 ? -v : v;
        m_dir   = v < 0;
        m_valid = 1;
    endtask

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            pipe = '{0, 0, 0};
            wins = '{0, 0, 0, 0};
            m_count = 0; m_acc = 0; m_phase = 0; m_vel = 0; m_pend = 0;
            m_dir = 0; m_valid = 0; m_err = 0;
        end else begin
            m_d = (ph(pipe[1]) - ph(pipe[2]) + 4) % 4;
            m_s = m_d == 1 ? 1 : m_d == 3 ? -1 : 0;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = {quad_a, quad_b};
            m_valid = 0;
            if (m_pend != 0) begin
                publish((wins[0] + wins[1] + wins[2] + wins[3]) >>> 2);
                m_pend = 0;
            end
            if (i_clear) begin
                m_count = 0; m_err = 0; m_acc = 0; m_phase = 0;
                wins = '{0, 0, 0, 0};
            end else begin
                m_count = (m_count + m_s + (1 << POS_W)) % (1 << POS_W);
                if (m_d == 2) m_err = 1;
                m_t = m_acc + m_s;
                if (m_t > SAT) m_t = SAT;
                if (m_t < -SAT) m_t = -SAT;
                if (m_phase == G - 1) begin
                    m_phase = 0;
                    m_acc = 0;
`ifdef QVM_AVG4_EN
                    wins = '{m_t, wins[0], wins[1], wins[2]};
                    m_pend = 1;
`else
                    publish(m_t);
`endif
                end else begin
                    m_acc = m_t;
                    m_phase++;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("count", o_count, m_count);
        chk("velocity", o_velocity, m_vel);
        chk("dir", o_dir, m_dir);
        chk("valid", o_valid, m_valid);
        chk("err", o_err, m_err);
    end

    int pins = 0;
    task automatic move(input int dir);
        pins = order[(ph(pins) + dir + 4) % 4];
        {quad_a, quad_b} = pins[1:0];
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_valid && n < 3 * G);
        chk({name, " strobe seen"}, o_valid, 1);
    endtask

    task automatic pulse_clear();
        i_clear = 1;
        cyc(1);
        i_clear = 0;
    endtask

    initial begin
        int n, r, g, bias;
`ifdef QVM_AVG4_EN
        int aw[5] = '{4, 8, 12, 16, -40};
        int av[5] = '{1, 3, 6, 10, 1};
        int ad[5] = '{0, 0, 0, 0, 1};
`endif
        cyc(3);
        chk("reset count", o_count, 0);
        chk("reset velocity", o_velocity, 0);
        chk("reset valid", o_valid, 0);
        chk("reset err", o_err, 0);
        #2 n_reset = 1;
        // Mid-window reset after five forward edges
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            move(1);
            cyc(2);
        end
        cyc(4);
        chk("pre-reset count", o_count, 5);
        #2 n_reset = 0;
        #1;
        chk("async reset count", o_count, 0);
        chk("async reset dir", o_dir, 0);
        chk("async reset err", o_err, 0);
        pins = 0;
        {quad_a, quad_b} = 2'b00;
        cyc(2);
        #2 n_reset = 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_valid && n < 3 * G);
        // Including the release cycle itself this is GATE_CYCLES+1 cycles (default build)
        chk("edges to first strobe", n, G + LAT - 1);

        for (int i = 0; i < 20; i++) begin
            move(1);
            cyc(4);
        end
        cyc(4);
        chk("20 fwd count", o_count, 20);
        wait_valid("20 fwd");
`ifndef QVM_AVG4_EN
        chk("20 fwd velocity", o_velocity, 20);
        chk("20 fwd dir", o_dir, 0);
`endif
        cyc(1);
        chk("strobe width", o_valid, 0);
        wait_valid("idle");
`ifndef QVM_AVG4_EN
        chk("idle velocity", o_velocity, 0);
        chk("idle dir", o_dir, 0);
`endif

        cyc(1);
        pulse_clear();
        chk("clear count", o_count, 0);
        for (int i = 0; i < 8; i++) begin
            move(-1);
            cyc(4);
        end
        cyc(4);
        chk("8 rev wrap count", o_count, 8184);
        wait_valid("8 rev");
`ifndef QVM_AVG4_EN
        chk("8 rev velocity", o_velocity, 8);
        chk("8 rev dir", o_dir, 1);
`endif

        move(2);
        cyc(5);
        chk("illegal err", o_err, 1);
        chk("illegal count held", o_count, 8184);
        wait_valid("illegal window");
        cyc(G - LAT);
        pulse_clear();
        chk("terminal clear err", o_err, 0);
        chk("terminal clear count", o_count, 0);
        chk("terminal clear no strobe", o_valid, 0);
        cyc(1);
        chk("terminal clear no late strobe", o_valid, 0);
        // Illegal transition landing on the clear cycle is discarded
        move(2);
        cyc(2);
        pulse_clear();
        cyc(2);
        chk("illegal with clear err", o_err, 0);

        // Phase is now 2; the tenth edge's step lands exactly on the terminal cycle
        for (int i = 0; i < 9; i++) begin
            move(1);
            cyc(5);
        end
        cyc(G - 3 - 47);
        move(1);
        cyc(2 + LAT);
        chk("terminal edge strobe", o_valid, 1);
`ifndef QVM_AVG4_EN
        chk("terminal edge window 1", o_velocity, 10);
`endif
        for (int i = 0; i < 10; i++) begin
            move(1);
            cyc(5);
        end
        wait_valid("window 2");
`ifndef QVM_AVG4_EN
        chk("terminal edge window 2", o_velocity, 10);
`endif
        chk("two window count", o_count, 20);

`ifdef QVM_AVG4_EN
        pulse_clear();
        for (int w = 0; w < 5; w++) begin
            for (int i = 0; i < (aw[w] < 0 ? -aw[w] : aw[w]); i++) begin
                move(aw[w] < 0 ? -1 : 1);
                cyc(2);
            end
            wait_valid("avg");
            chk("avg velocity", o_velocity, av[w]);
            chk("avg dir", o_dir, ad[w]);
        end
`endif

        n = 0;
        bias = 70;
        while (n < 6 * G) begin
            if ($urandom_range(0, 199) == 0) bias = $urandom_range(0, 100);
            r = $urandom_range(0, 99);
            if (r < 2) move(2);
            else if ($urandom_range(0, 99) < bias) move(1);
            else move(-1);
            if ($urandom_range(0, 299) == 0) begin
                pulse_clear();
                n++;
            end
            g = $urandom_range(1, 6);
            cyc(g);
            n += g;
        end
        cyc(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
